// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle CPU control unit.
package cpu_ctrl_pkg;

  // Controller sequencing states; HALT is only entered when halt-on-illegal is built in
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  // Supported primary opcodes (instruction [31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  // Next-PC mux selects
  localparam logic [1:0] PCSEL_INC  = 2'd0;
  localparam logic [1:0] PCSEL_IMM  = 2'd1;
  localparam logic [1:0] PCSEL_ADDR = 2'd2;

endpackage

// File: rtl/cpu_ctrl_decode.sv
// Combinational instruction classifier fed from the latched opcode/funct.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
#(
  parameter logic [5:0] ALU_ADD = 6'h20,
  parameter logic [5:0] ALU_SUB = 6'h22
) (
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic       is_r,
  output logic       is_i,
  output logic       is_j,
  output logic [5:0] alu_op,
  output logic       needs_rt,
  output logic       is_mem,
  output logic       is_store,
  output logic       illegal
);

  // Classify the opcode into type, ALU operation and operand/memory needs
  always_comb begin
    is_r     = 1'b0;
    is_i     = 1'b0;
    is_j     = 1'b0;
    alu_op   = 6'd0;
    needs_rt = 1'b0;
    is_mem   = 1'b0;
    is_store = 1'b0;
    illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        is_r     = 1'b1;
        alu_op   = funct;
        needs_rt = 1'b1;
      end
      OP_ADDI: begin
        is_i   = 1'b1;
        alu_op = ALU_ADD;
      end
      OP_LW: begin
        is_i   = 1'b1;
        alu_op = ALU_ADD;
        is_mem = 1'b1;
      end
      OP_SW: begin
        is_i     = 1'b1;
        alu_op   = ALU_ADD;
        needs_rt = 1'b1;
        is_mem   = 1'b1;
        is_store = 1'b1;
      end
      OP_BEQ: begin
        is_i     = 1'b1;
        alu_op   = ALU_SUB;
        needs_rt = 1'b1;
      end
      OP_J: begin
        is_j = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with hazard stalls in DECODE.
// Outputs are Moore registers: each transition loads the outputs of the state being entered.
// Optional build macro CPU_CTRL_HALT_ON_ILLEGAL_EN: illegal opcodes enter a sticky HALT
// state and the extra 'halted' output exists; otherwise illegal opcodes retire as NOPs.
module cpu_control_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STALL = 8,
  parameter logic [5:0]  ALU_ADD   = 6'h20,
  parameter logic [5:0]  ALU_SUB   = 6'h22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       is_alu_zero,
  input  logic       is_full_rnum1,
  input  logic       is_full_rnum2,
  output logic       is_load_PC,
  output logic [1:0] control_mux_for_PC,
  output logic       is_write_reg,
  output logic       is_write_mem,
  output logic       is_write_from_mem,
  output logic       is_R_type,
  output logic       is_I_type,
  output logic       is_J_type,
  output logic [5:0] opcode_alu,
  output logic       stalled,
  output logic       instr_done
`ifdef CPU_CTRL_HALT_ON_ILLEGAL_EN
  ,
  output logic       halted
`endif
);

  localparam logic [7:0] MAX_STALL_C = MAX_STALL[7:0];

  state_t     state_r;
  logic [7:0] stall_cnt_r;
  logic [5:0] opcode_r;
  logic [5:0] funct_r;

  logic       dec_r_s;
  logic       dec_i_s;
  logic       dec_j_s;
  logic [5:0] dec_alu_s;
  logic       dec_needs_rt_s;
  logic       dec_is_mem_s;
  logic       dec_is_store_s;
  logic       dec_illegal_s;
  logic       hazard_s;

  cpu_ctrl_decode #(
    .ALU_ADD (ALU_ADD),
    .ALU_SUB (ALU_SUB)
  ) u_decode (
    .opcode   (opcode_r),
    .funct    (funct_r),
    .is_r     (dec_r_s),
    .is_i     (dec_i_s),
    .is_j     (dec_j_s),
    .alu_op   (dec_alu_s),
    .needs_rt (dec_needs_rt_s),
    .is_mem   (dec_is_mem_s),
    .is_store (dec_is_store_s),
    .illegal  (dec_illegal_s)
  );

  // rt only matters for instructions that actually read it
  assign hazard_s = is_full_rnum1 | (is_full_rnum2 & dec_needs_rt_s);

  // Sequencer: state, stall counter, instruction latch and every registered output
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r            <= FETCH;
      stall_cnt_r        <= 8'd0;
      opcode_r           <= 6'd0;
      funct_r            <= 6'd0;
      is_load_PC         <= 1'b0;
      control_mux_for_PC <= PCSEL_INC;
      is_write_reg       <= 1'b0;
      is_write_mem       <= 1'b0;
      is_write_from_mem  <= 1'b0;
      is_R_type          <= 1'b0;
      is_I_type          <= 1'b0;
      is_J_type          <= 1'b0;
      opcode_alu         <= 6'd0;
      stalled            <= 1'b0;
      instr_done         <= 1'b0;
`ifdef CPU_CTRL_HALT_ON_ILLEGAL_EN
      halted             <= 1'b0;
`endif
    end else begin
      // Strobes and per-instruction outputs drop unless the entered state asserts them
      is_load_PC         <= 1'b0;
      control_mux_for_PC <= PCSEL_INC;
      is_write_reg       <= 1'b0;
      is_write_mem       <= 1'b0;
      is_write_from_mem  <= 1'b0;
      is_R_type          <= 1'b0;
      is_I_type          <= 1'b0;
      is_J_type          <= 1'b0;
      opcode_alu         <= 6'd0;
      stalled            <= 1'b0;
      instr_done         <= 1'b0;
      case (state_r)
        FETCH: begin
          // Instruction word is valid during FETCH; capture it on the way into DECODE
          opcode_r <= opcode;
          funct_r  <= funct;
          state_r  <= DECODE;
        end
        DECODE: begin
          if (hazard_s && (stall_cnt_r < MAX_STALL_C)) begin
            stall_cnt_r <= stall_cnt_r + 8'd1;
            stalled     <= 1'b1;
            state_r     <= DECODE;
          end else if (dec_illegal_s) begin
            stall_cnt_r <= 8'd0;
`ifdef CPU_CTRL_HALT_ON_ILLEGAL_EN
            halted      <= 1'b1;
            state_r     <= HALT;
`else
            // Illegal opcode retires as a NOP: sequential PC load in EXEC
            is_load_PC  <= 1'b1;
            instr_done  <= 1'b1;
            state_r     <= EXEC;
`endif
          end else begin
            stall_cnt_r <= 8'd0;
            is_R_type   <= dec_r_s;
            is_I_type   <= dec_i_s;
            is_J_type   <= dec_j_s;
            opcode_alu  <= dec_alu_s;
            state_r     <= EXEC;
            if (dec_j_s) begin
              is_load_PC         <= 1'b1;
              instr_done         <= 1'b1;
              control_mux_for_PC <= PCSEL_ADDR;
            end else if (opcode_r == OP_BEQ) begin
              // Branch outcome is taken from the zero flag at the DECODE->EXEC edge
              is_load_PC         <= 1'b1;
              instr_done         <= 1'b1;
              control_mux_for_PC <= is_alu_zero ? PCSEL_IMM : PCSEL_INC;
            end else begin
              is_load_PC <= 1'b0;
            end
          end
        end
        EXEC: begin
          if (dec_j_s || dec_illegal_s || (opcode_r == OP_BEQ)) begin
            state_r <= FETCH;
          end else if (dec_is_mem_s) begin
            is_R_type  <= dec_r_s;
            is_I_type  <= dec_i_s;
            is_J_type  <= dec_j_s;
            opcode_alu <= dec_alu_s;
            state_r    <= MEM;
            if (dec_is_store_s) begin
              is_write_mem <= 1'b1;
              is_load_PC   <= 1'b1;
              instr_done   <= 1'b1;
            end else begin
              is_write_mem <= 1'b0;
            end
          end else begin
            is_R_type    <= dec_r_s;
            is_I_type    <= dec_i_s;
            is_J_type    <= dec_j_s;
            opcode_alu   <= dec_alu_s;
            is_write_reg <= 1'b1;
            is_load_PC   <= 1'b1;
            instr_done   <= 1'b1;
            state_r      <= WB;
          end
        end
        MEM: begin
          if (dec_is_store_s) begin
            state_r <= FETCH;
          end else begin
            is_R_type         <= dec_r_s;
            is_I_type         <= dec_i_s;
            is_J_type         <= dec_j_s;
            opcode_alu        <= dec_alu_s;
            is_write_reg      <= 1'b1;
            is_write_from_mem <= 1'b1;
            is_load_PC        <= 1'b1;
            instr_done        <= 1'b1;
            state_r           <= WB;
          end
        end
        WB: begin
          state_r <= FETCH;
        end
`ifdef CPU_CTRL_HALT_ON_ILLEGAL_EN
        HALT: begin
          halted  <= 1'b1;
          state_r <= HALT;
        end
`endif
        default: begin
          state_r <= FETCH;
        end
      endcase
    end
  end

endmodule
